// File: rtl/mole_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mole_ctrl
//  Description : Whack-a-mole round sequencer. It requests a random mole mask,
//                shows it for a fixed tick window and scores button presses.
//  Revision    : 1.0 - initial release
// ============================================================================
module mole_ctrl #(
    parameter int UP_TICKS  = 1000,
    parameter int GAP_TICKS = 250,
    parameter int ROUNDS    = 20,
    parameter int RAND_LAT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        start,
    input  logic [17:0] random_value,
    input  logic [17:0] buttons,
    output logic        change,
    output logic [17:0] leds,
    output logic [9:0]  score,
    output logic [7:0]  misses,
    output logic [7:0]  round_no,
    output logic        game_over
);

    localparam int c_UP_W  = (UP_TICKS  > 2) ? $clog2(UP_TICKS)  : 1;
    localparam int c_GAP_W = (GAP_TICKS > 2) ? $clog2(GAP_TICKS) : 1;
    localparam int c_LAT_W = (RAND_LAT  > 2) ? $clog2(RAND_LAT)  : 1;

    localparam logic [c_UP_W-1:0]  c_UP_LAST  = c_UP_W'((UP_TICKS  > 0) ? UP_TICKS  - 1 : 0);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam logic [c_LAT_W-1:0] c_LAT_LAST = c_LAT_W'((RAND_LAT  > 0) ? RAND_LAT  - 1 : 0);
    localparam bit                 c_UP_ZERO  = (UP_TICKS  == 0);
    localparam bit                 c_GAP_ZERO = (GAP_TICKS == 0);
    localparam bit                 c_LAT_ZERO = (RAND_LAT  == 0);
    localparam logic [7:0]         c_ROUNDS   = 8'(ROUNDS);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_SHOW = 3'd3,
        S_GAP  = 3'd4,
        S_OVER = 3'd5
    } state_t;

    state_t               r_state,   w_state_nxt;
    logic [17:0]          r_leds,    w_leds_nxt;
    logic [9:0]           r_score,   w_score_nxt;
    logic [7:0]           r_misses,  w_misses_nxt;
    logic [7:0]           r_round,   w_round_nxt;
    logic [c_UP_W-1:0]    r_up,      w_up_nxt;
    logic [c_GAP_W-1:0]   r_gap,     w_gap_nxt;
    logic [c_LAT_W-1:0]   r_wait,    w_wait_nxt;
    logic [17:0]          r_btn_prev;

    logic [17:0] w_edges;
    logic [17:0] w_hits;
    logic [17:0] w_wrong;
    logic [17:0] w_leds_after;
    logic        w_up_done;
    logic        w_gap_done;
    logic        w_wait_done;
    logic        w_timeout_miss;
    logic [10:0] w_score_sum;
    logic [9:0]  w_miss_sum;

    function automatic logic [4:0] popcount18(input logic [17:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 18; i++) begin
            n = n + 5'(v[i]);
        end
        return n;
    endfunction

    // Press evaluation: hits clear their LEDs first so a timeout in the same
    // cycle only penalises moles that are still lit afterwards.
    always_comb begin
        w_edges        = buttons & ~r_btn_prev;
        w_hits         = '0;
        w_wrong        = '0;
        if (r_state == S_SHOW) begin
            w_hits  = w_edges & r_leds;
            w_wrong = w_edges & ~r_leds;
        end
        w_leds_after   = r_leds & ~w_hits;
        w_up_done      = c_UP_ZERO  || (tick && (r_up  == c_UP_LAST));
        w_gap_done     = c_GAP_ZERO || (tick && (r_gap == c_GAP_LAST));
        w_wait_done    = c_LAT_ZERO || (r_wait == c_LAT_LAST);
        w_timeout_miss = (r_state == S_SHOW) && (r_leds != '0) && w_up_done && (w_leds_after != '0);
        w_score_sum    = {1'b0, r_score} + 11'(popcount18(w_hits));
        w_miss_sum     = {2'b00, r_misses} + 10'(popcount18(w_wrong)) + 10'(w_timeout_miss);
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_leds_nxt   = r_leds;
        w_score_nxt  = r_score;
        w_misses_nxt = r_misses;
        w_round_nxt  = r_round;
        w_up_nxt     = r_up;
        w_gap_nxt    = r_gap;
        w_wait_nxt   = r_wait;
        change       = 1'b0;
        game_over    = 1'b0;

        case (r_state)
            S_IDLE, S_OVER: begin
                game_over = (r_state == S_OVER);
                if (start) begin
                    w_state_nxt  = S_REQ;
                    w_score_nxt  = '0;
                    w_misses_nxt = '0;
                    w_round_nxt  = '0;
                end
            end
            S_REQ: begin
                change      = 1'b1;
                w_round_nxt = r_round + 8'd1;
                w_wait_nxt  = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (w_wait_done) begin
                    w_leds_nxt  = (random_value == '0) ? 18'h00001 : random_value;
                    w_up_nxt    = '0;
                    w_state_nxt = S_SHOW;
                end else begin
                    w_wait_nxt = r_wait + 1'b1;
                end
            end
            S_SHOW: begin
                w_score_nxt  = (w_score_sum > 11'd1023) ? 10'd1023 : w_score_sum[9:0];
                w_misses_nxt = (w_miss_sum > 10'd255) ? 8'd255 : w_miss_sum[7:0];
                w_leds_nxt   = w_leds_after;
                if (r_leds == '0) begin
                    w_state_nxt = S_GAP;
                    w_gap_nxt   = '0;
                end else if (w_up_done) begin
                    w_leds_nxt  = '0;
                    w_state_nxt = S_GAP;
                    w_gap_nxt   = '0;
                end else if (tick) begin
                    w_up_nxt = r_up + 1'b1;
                end
            end
            S_GAP: begin
                if (w_gap_done) begin
                    w_state_nxt = (r_round < c_ROUNDS) ? S_REQ : S_OVER;
                end else if (tick) begin
                    w_gap_nxt = r_gap + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_leds_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_leds     <= '0;
            r_score    <= '0;
            r_misses   <= '0;
            r_round    <= '0;
            r_up       <= '0;
            r_gap      <= '0;
            r_wait     <= '0;
            r_btn_prev <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_leds     <= w_leds_nxt;
            r_score    <= w_score_nxt;
            r_misses   <= w_misses_nxt;
            r_round    <= w_round_nxt;
            r_up       <= w_up_nxt;
            r_gap      <= w_gap_nxt;
            r_wait     <= w_wait_nxt;
            r_btn_prev <= buttons;
        end
    end

    assign leds     = r_leds;
    assign score    = r_score;
    assign misses   = r_misses;
    assign round_no = r_round;

endmodule
`default_nettype wire

// File: doc/mole_ctrl.md
MOLE_CTRL -- requirements
Module: mole_ctrl

Interface
REQ-001 SHALL have parameter UP_TICKS, default 1000, meaning tick count a mole set stays lit per round.
REQ-002 SHALL have parameter GAP_TICKS, default 250, meaning tick count between rounds, LEDs dark.
REQ-003 SHALL have parameter ROUNDS, default 20, meaning rounds per game (1..255).
REQ-004 SHALL have parameter RAND_LAT, default 2, meaning clk cycles from change pulse to valid random value.
REQ-005 SHALL have port clk input 1, system clock, all logic on rising edge.
REQ-006 SHALL have port reset input 1, synchronous, active-low.
REQ-007 SHALL have port tick input 1, single-cycle timebase enable (e.g. 1 ms).
REQ-008 SHALL have port start input 1, level; sampled in IDLE and OVER only.
REQ-009 SHALL have port random_value input 18, mole mask source from the random number generator.
REQ-010 SHALL have port buttons input 18, player hole buttons, already synchronous, not debounced.
REQ-011 SHALL have port change output 1, single-cycle request for a new random value.
REQ-012 SHALL have port leds output 18, lit moles.
REQ-013 SHALL have port score output 10, hits, saturating at 1023.
REQ-014 SHALL have port misses output 8, penalty count, saturating at 255.
REQ-015 SHALL have port round_no output 8, rounds started this game.
REQ-016 SHALL have port game_over output 1, high in OVER.

Function
REQ-017 SHALL implement states IDLE, REQ, WAIT, SHOW, GAP, OVER.
REQ-018 IDLE: start=1 -> REQ; score, misses, round_no cleared on this transition.
REQ-019 REQ: change=1 for exactly one cycle, round_no+1, -> WAIT; change SHALL be 0 in all other states.
REQ-020 WAIT: count RAND_LAT cycles, then latch mask = random_value; mask==0 -> mask=18'h00001; leds<=mask, up-timer cleared, -> SHOW.
REQ-021 SHOW: up-timer +1 on each tick; leave SHOW when leds==0 or up-timer reaches UP_TICKS.
REQ-022 Button press = rising edge of a buttons bit (registered previous value, per bit, reset to 0); edges detected only in SHOW.
REQ-023 Edge on lit bit -> clear that leds bit next cycle, score += 1 per such bit.
REQ-024 Edge on unlit bit -> misses += 1 per such bit.
REQ-025 Multiple simultaneous edges SHALL be counted in the same cycle (popcount, up to 18 each).
REQ-026 Timeout with leds!=0 -> misses += 1 (once per round), leds<=0.
REQ-027 Hit and timeout in the same cycle: hits processed first; timeout miss only if leds still nonzero after hits.
REQ-028 Score and misses SHALL saturate, never wrap.
REQ-029 Exit SHOW -> GAP, gap-timer cleared; GAP lasts GAP_TICKS ticks, leds=0.
REQ-030 GAP end: round_no<ROUNDS -> REQ, else -> OVER.
REQ-031 OVER: game_over=1, score/misses/round_no held; start=1 -> REQ with counters cleared as in REQ-018.
REQ-032 tick in non-timing states SHALL be ignored; start in REQ/WAIT/SHOW/GAP SHALL be ignored.
REQ-033 Button edge stored on the cycle of leaving SHOW SHALL not carry into next round.

Reset
REQ-034 reset=0 at a clk edge SHALL force IDLE, leds=0, score=0, misses=0, round_no=0, game_over=0, change=0, timers=0, button history=0, regardless of state.
REQ-035 Reset mid-round SHALL discard the latched mask; first round after reset SHALL request a fresh value.

Verification
REQ-036 Reset then start=1, random_value=18'h00005 -> change pulse 1 cycle, RAND_LAT later leds=18'h00005, round_no=1.
REQ-037 In SHOW with leds=18'h00005, buttons bits 0 and 2 rise same cycle -> leds=0, score=2, misses=0, enters GAP next cycle.
REQ-038 random_value=0 -> leds=18'h00001; no press for UP_TICKS ticks -> misses=1, leds=0, GAP.
REQ-039 leds=18'h00001, buttons bit 3 rises -> misses=1, leds unchanged; bit 0 held high across rounds -> no second hit without a new rising edge.
REQ-040 ROUNDS=2, two rounds complete -> game_over=1, score/misses held; start=1 -> counters cleared, round_no=1.
REQ-041 reset=0 during SHOW with leds=18'h3FFFF, score=7 -> next cycle all outputs zero, state IDLE.
